// File: rtl/seq_det_prog.sv
// seq_det_prog: serial bit-pattern detector with a runtime-loadable pattern and
// don't-care mask, selectable overlapping/non-overlapping detection, and a
// registered one-cycle match pulse.
// Optional saturating match counter enabled by defining SEQ_DET_PROG_CNT_EN;
// without it the count port is tied to zero and cnt_clr is ignored.
module seq_det_prog #(
  parameter int                 PAT_LEN  = 3,
  parameter logic [PAT_LEN-1:0] RST_PAT  = PAT_LEN'(3'b101),
  parameter logic [PAT_LEN-1:0] RST_MASK = '1,
  parameter int                 CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic [PAT_LEN-1:0] mask_in,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   count
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_LEN);

  // FILL while fewer than PAT_LEN valid bits are held; ARMED once the history is full
  typedef enum logic {FILL, ARMED} state_t;

  state_t             state_reg, state_next;
  logic [PAT_LEN-1:0] pat_reg, pat_next;
  logic [PAT_LEN-1:0] mask_reg, mask_next;
  logic [PAT_LEN-1:0] hist_reg, hist_next;
  logic [FILL_W-1:0]  fill_reg, fill_next;
  logic               out_reg, out_next;

  logic [PAT_LEN-1:0] shifted;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;

  // Next-state logic: a load wins over a same-cycle data bit; idle cycles hold everything
  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    mask_next  = mask_reg;
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    match      = 1'b0;
    shifted    = {hist_reg[PAT_LEN-2:0], in};
    fill_inc   = (fill_reg == FULL) ? FULL : fill_reg + FILL_W'(1);

    if (pat_load) begin
      pat_next   = pat_in;
      mask_next  = mask_in;
      hist_next  = '0;
      fill_next  = '0;
      state_next = FILL;
    end else if (in_valid) begin
      hist_next  = shifted;
      fill_next  = fill_inc;
      state_next = (fill_inc == FULL) ? ARMED : FILL;
      // Only compare once the history window holds PAT_LEN real bits
      match = (state_next == ARMED) && (((shifted ^ pat_reg) & mask_reg) == '0);
      if (match && !overlap) begin
        // Non-overlapping: the next match must be built from PAT_LEN fresh bits
        fill_next  = '0;
        state_next = FILL;
      end
    end

    out_next = match;
  end

  // Detector state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= FILL;
      pat_reg   <= RST_PAT;
      mask_reg  <= RST_MASK;
      hist_reg  <= '0;
      fill_reg  <= '0;
      out_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      mask_reg  <= mask_next;
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      out_reg   <= out_next;
    end
  end

  assign out = out_reg;

`ifdef SEQ_DET_PROG_CNT_EN
  logic [CNT_W-1:0] count_reg;

  // Saturating match counter; a clear beats a same-cycle match
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (cnt_clr) begin
      count_reg <= '0;
    end else if (out_next && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;
`else
  // Counter not built: the port stays at zero and the clear strobe has no effect
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign count = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: table-driven check of seq_det_prog plus hand-written
// asynchronous-reset sequences. A second instance with CNT_W=2 shares the
// stimulus to observe counter saturation.
module tb_seq_det_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, din, overlap, pat_load, cnt_clr;
  logic [2:0] pat_in, mask_in;
  logic       out1, out2;
  logic [7:0] count1;
  logic [1:0] count2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_det_prog dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .mask_in(mask_in), .cnt_clr(cnt_clr),
    .out(out1), .count(count1)
  );

  seq_det_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .mask_in(mask_in), .cnt_clr(cnt_clr),
    .out(out2), .count(count2)
  );

  typedef struct {
    logic       ld;
    logic [2:0] pat;
    logic [2:0] msk;
    logic       vld;
    logic       b;
    logic       ovl;
    logic       clr;
    logic       eo;
    int         ec;   // expected count of the full-width counter when it is built
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic ld, logic [2:0] pat, logic [2:0] msk, logic vld,
                             logic b, logic ovl, logic clr, logic eo, int ec);
    vec_t r;
    r.ld = ld; r.pat = pat; r.msk = msk; r.vld = vld; r.b = b;
    r.ovl = ovl; r.clr = clr; r.eo = eo; r.ec = ec;
    return r;
  endfunction

  function automatic int exp_cnt1(int ec);
`ifdef SEQ_DET_PROG_CNT_EN
    return ec;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_cnt2(int ec);
`ifdef SEQ_DET_PROG_CNT_EN
    return (ec > 3) ? 3 : ec;
`else
    return 0;
`endif
  endfunction

  task automatic check(string name, int actual, int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // Drive one cycle of inputs at the falling edge, sample 1 time unit after the rising edge
  task automatic drive(logic ld, logic [2:0] pat, logic [2:0] msk, logic vld,
                       logic b, logic ovl, logic clr);
    @(negedge clk);
    pat_load = ld; pat_in = pat; mask_in = msk; in_valid = vld;
    din = b; overlap = ovl; cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(logic b);
    drive(1'b0, 3'b000, 3'b000, 1'b1, b, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; din = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = '0; mask_in = '0; cnt_clr = 1'b0;

    // Overlap, default pattern 101: pulses after 3rd and 5th bits
    vecs.push_back(v(0,3'b000,3'b000,1,1,1,0,0,0));
    vecs.push_back(v(0,3'b000,3'b000,1,0,1,0,0,0));
    vecs.push_back(v(0,3'b000,3'b000,1,1,1,0,1,1));
    vecs.push_back(v(0,3'b000,3'b000,1,0,1,0,0,1));
    vecs.push_back(v(0,3'b000,3'b000,1,1,1,0,1,2));
    // Reload default pattern and clear counter
    vecs.push_back(v(1,3'b101,3'b111,0,0,0,1,0,0));
    // Non-overlap: single pulse after 3rd bit
    vecs.push_back(v(0,3'b000,3'b000,1,1,0,0,0,0));
    vecs.push_back(v(0,3'b000,3'b000,1,0,0,0,0,0));
    vecs.push_back(v(0,3'b000,3'b000,1,1,0,0,1,1));
    vecs.push_back(v(0,3'b000,3'b000,1,0,0,0,0,1));
    vecs.push_back(v(0,3'b000,3'b000,1,1,0,0,0,1));
    // Pattern 110 mask 101, non-overlap: 1,1,0 then 1,0,0
    vecs.push_back(v(1,3'b110,3'b101,0,0,0,0,0,1));
    vecs.push_back(v(0,3'b000,3'b000,1,1,0,0,0,1));
    vecs.push_back(v(0,3'b000,3'b000,1,1,0,0,0,1));
    vecs.push_back(v(0,3'b000,3'b000,1,0,0,0,1,2));
    vecs.push_back(v(0,3'b000,3'b000,1,1,0,0,0,2));
    vecs.push_back(v(0,3'b000,3'b000,1,0,0,0,0,2));
    vecs.push_back(v(0,3'b000,3'b000,1,0,0,0,1,3));
    // Load with a same-cycle valid bit: that bit must be discarded
    vecs.push_back(v(1,3'b101,3'b111,1,1,1,0,0,3));
    vecs.push_back(v(0,3'b000,3'b000,1,0,1,0,0,3));
    vecs.push_back(v(0,3'b000,3'b000,1,1,1,0,0,3));
    vecs.push_back(v(0,3'b000,3'b000,1,0,1,0,0,3));
    vecs.push_back(v(0,3'b000,3'b000,1,1,1,0,1,4));
    // All-zero mask: every bit once armed (overlap), every 3 bits (non-overlap)
    vecs.push_back(v(1,3'b101,3'b000,0,0,1,0,0,4));
    vecs.push_back(v(0,3'b000,3'b000,1,0,1,0,0,4));
    vecs.push_back(v(0,3'b000,3'b000,1,1,1,0,0,4));
    vecs.push_back(v(0,3'b000,3'b000,1,0,1,0,1,5));
    vecs.push_back(v(0,3'b000,3'b000,1,1,1,0,1,6));
    vecs.push_back(v(0,3'b000,3'b000,1,1,0,0,1,7));
    vecs.push_back(v(0,3'b000,3'b000,1,0,0,0,0,7));
    vecs.push_back(v(0,3'b000,3'b000,1,0,0,0,0,7));
    vecs.push_back(v(0,3'b000,3'b000,1,1,0,0,1,8));
    // Idle gap between bits: 1, three idle cycles, 0, 1
    vecs.push_back(v(1,3'b101,3'b111,0,0,1,0,0,8));
    vecs.push_back(v(0,3'b000,3'b000,1,1,1,0,0,8));
    vecs.push_back(v(0,3'b000,3'b000,0,0,1,0,0,8));
    vecs.push_back(v(0,3'b000,3'b000,0,1,1,0,0,8));
    vecs.push_back(v(0,3'b000,3'b000,0,0,1,0,0,8));
    vecs.push_back(v(0,3'b000,3'b000,1,0,1,0,0,8));
    vecs.push_back(v(0,3'b000,3'b000,1,1,1,0,1,9));
    // Clear and match in the same cycle: count ends at zero
    vecs.push_back(v(0,3'b000,3'b000,1,0,1,0,0,9));
    vecs.push_back(v(0,3'b000,3'b000,1,1,1,1,1,0));
    vecs.push_back(v(0,3'b000,3'b000,0,0,1,0,0,0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset out", int'(out1), 0);
    check("reset count", int'(count1), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset out", int'(out1), 0);

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].pat, vecs[i].msk, vecs[i].vld,
            vecs[i].b, vecs[i].ovl, vecs[i].clr);
      check($sformatf("v%0d out", i), int'(out1), int'(vecs[i].eo));
      check($sformatf("v%0d count", i), int'(count1), exp_cnt1(vecs[i].ec));
      check($sformatf("v%0d out w2", i), int'(out2), int'(vecs[i].eo));
      check($sformatf("v%0d count w2", i), int'(count2), exp_cnt2(vecs[i].ec));
      $display("vec %0d ld=%0b vld=%0b in=%0b ovl=%0b clr=%0b -> out=%0b count=%0d count_w2=%0d",
               i, vecs[i].ld, vecs[i].vld, vecs[i].b, vecs[i].ovl, vecs[i].clr,
               out1, count1, count2);
    end

    // Asynchronous reset while out is high clears it before the next edge
    drive(1'b1, 3'b101, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    check("pre-async out", int'(out1), 1);
    #2 rst = 1'b0;
    #1;
    check("async out", int'(out1), 0);
    check("async count", int'(count1), 0);
    $display("async reset mid-cycle: out=%0b count=%0d", out1, count1);
    #1 rst = 1'b1;

    // Bits 1,0, reset pulse, then 1: no pulse; then 0,1 completes 101 from scratch
    bit_in(1'b1); bit_in(1'b0);
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    bit_in(1'b1);
    check("after rst bit1 out", int'(out1), 0);
    check("after rst count", int'(count1), 0);
    bit_in(1'b0);
    check("after rst bit2 out", int'(out1), 0);
    bit_in(1'b1);
    check("after rst bit3 out", int'(out1), 1);
    check("after rst final count", int'(count1), exp_cnt1(1));
    $display("post-reset restart: out=%0b count=%0d", out1, count1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_det_prog.md
SEQ_DET_PROG -- requirements
Module: seq_det_prog

Interface
REQ-001 Parameter PAT_LEN, default 3, pattern length in bits (legal 2..16).
REQ-002 Parameter RST_PAT, default 3'b101, pattern after reset (PAT_LEN bits).
REQ-003 Parameter RST_MASK, default all ones, compare mask after reset (PAT_LEN bits).
REQ-004 Parameter CNT_W, default 8, match counter width (legal 1..32).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  qualifies in; a bit is consumed only on an edge where in_valid=1.
REQ-008 in  input  1  serial data bit.
REQ-009 overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled per bit.
REQ-010 pat_load  input  1  load strobe for pat_in/mask_in.
REQ-011 pat_in  input  PAT_LEN  new pattern; bit PAT_LEN-1 is the first bit received.
REQ-012 mask_in  input  PAT_LEN  new mask; 1 = compare bit, 0 = don't care.
REQ-013 cnt_clr  input  1  synchronous clear of match counter.
REQ-014 out  output  1  registered match pulse.
REQ-015 count  output  CNT_W  saturating match count.

Function
REQ-016 History register hist (PAT_LEN bits) shall shift left on each consumed bit, new bit into bit 0.
REQ-017 Fill counter fill (0..PAT_LEN) shall increment per consumed bit, saturating at PAT_LEN.
REQ-018 FSM shall have two states: FILL (fill<PAT_LEN) and ARMED (fill=PAT_LEN); match evaluated only on entry to or while in ARMED.
REQ-019 Match shall be ((hist_next XOR pat) AND mask)=0 with fill_next=PAT_LEN, on an edge consuming a bit.
REQ-020 out shall be 1 for exactly the one clock following the edge that consumes the completing bit; 0 otherwise, including cycles with in_valid=0.
REQ-021 Overlap=1 at match: fill stays PAT_LEN, FSM stays ARMED.
REQ-022 Overlap=0 at match: fill forced to 0, FSM to FILL; next match needs PAT_LEN fresh bits.
REQ-023 All-zero mask shall match on every consumed bit once ARMED (overlap=1) or every PAT_LEN bits (overlap=0).
REQ-024 pat_load=1 shall load pat/mask, clear hist and fill, enter FILL, and drive out=0 next cycle; pat_load has priority over a same-cycle in_valid, whose bit is discarded.
REQ-025 Idle cycles (in_valid=0) shall hold hist, fill, FSM state unchanged.

Reset
REQ-026 rst=0 shall asynchronously set pat=RST_PAT, mask=RST_MASK, hist=0, fill=0, FSM=FILL, out=0, count=0.
REQ-027 Reset asserted mid-sequence shall discard all partial history; detection restarts from fill=0 after release.

Configuration
REQ-028 Macro SEQ_DET_PROG_CNT_EN defined: count increments by 1 on each out pulse, saturates at 2^CNT_W-1, cnt_clr clears to 0; cnt_clr and match same cycle -> count=0.
REQ-029 Macro not defined: no counter logic; count port present and tied to 0; cnt_clr ignored.

Verification
REQ-030 Defaults, overlap=1, bits 1,0,1,0,1 consecutive -> out pulses after 3rd and 5th bits; count=2 (with macro).
REQ-031 Defaults, overlap=0, bits 1,0,1,0,1 -> single pulse after 3rd bit; count=1.
REQ-032 pat_load pat_in=3'b110 mask_in=3'b101, overlap=0, bits 1,1,0 then 1,0,0 -> pulse after 3rd and 6th bits.
REQ-033 Bits 1, three in_valid=0 cycles, 0, 1 -> exactly one pulse, after final bit; out=0 during gap.
REQ-034 Bits 1,0, rst pulsed low mid-cycle (async), then bit 1 -> no pulse; count=0.
REQ-035 CNT_W=2, macro defined, 5 matches -> count=3; cnt_clr one cycle -> count=0; without macro count=0 throughout.
